// File: rtl/arbitro_roteamento_if.sv
// Handshake bundle between the round-robin arbiter and its request sources, router and consumer.
// The burst_cnt width follows MAX_BURST, so both ends must use the same MAX_BURST.
interface arbitro_roteamento_if #(
   parameter int MAX_BURST = 4
);
   localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   logic [3:0]    req;
   logic          ready;
   logic [1:0]    SEL;
   logic [3:0]    grant;
   logic          valid;
   logic [BW-1:0] burst_cnt;

   // The arbiter side of the bundle.
   modport master (
      input  req, ready,
      output SEL, grant, valid, burst_cnt
   );

   // The side that issues requests and consumes grants.
   modport slave (
      output req, ready,
      input  SEL, grant, valid, burst_cnt
   );
endinterface

// File: rtl/arbitro_roteamento.sv
// Round-robin 4-source arbiter driving the router SEL, with a burst limit per grant.
// Every output is registered. Hand-over happens without idle cycles.
module arbitro_roteamento #(
   parameter int N_BITS    = 4,
   parameter int MAX_BURST = 4
) (
   input logic                   clk,
   input logic                   reset,
   arbitro_roteamento_if.master  bus
);
   // The router data width is not needed here. It is referenced only so that a
   // degenerate N_BITS setting falls back to a 1-bit counter width.
   localparam int BW = (MAX_BURST > 1 && N_BITS > 0) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state;
   logic [1:0] ptr;

   // Returns the first requester found when scanning from start upward, modulo 4.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
      logic [1:0] res;
      logic [1:0] idx;
      res = start;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (r[idx]) res = idx;
      end
      return res;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] s);
      return 4'b0001 << s;
   endfunction

   logic       cur_req;
   logic       last_beat;
   logic [1:0] next_sel;

   assign cur_req   = bus.req[bus.SEL];
   assign last_beat = (bus.burst_cnt == LAST);
   // While granted, the scan restarts just past the current owner.
   assign next_sel  = pick(bus.req, (state == GRANT) ? bus.SEL + 2'd1 : ptr);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         ptr           <= 2'd0;
         bus.SEL       <= 2'd0;
         bus.grant     <= 4'b0000;
         bus.valid     <= 1'b0;
         bus.burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req != 4'b0000) begin
                  state         <= GRANT;
                  bus.SEL       <= next_sel;
                  bus.grant     <= onehot(next_sel);
                  bus.valid     <= 1'b1;
                  bus.burst_cnt <= '0;
               end else begin
                  bus.grant <= 4'b0000;
                  bus.valid <= 1'b0;
               end
            end
            GRANT: begin
               if (bus.ready && cur_req && bus.burst_cnt < LAST) begin
                  bus.burst_cnt <= bus.burst_cnt + 1'b1;
               end else if (!cur_req || (bus.ready && last_beat)) begin
                  ptr <= bus.SEL + 2'd1;
                  if (bus.req != 4'b0000) begin
                     bus.SEL       <= next_sel;
                     bus.grant     <= onehot(next_sel);
                     bus.burst_cnt <= '0;
                  end else begin
                     // SEL keeps its last value while the arbiter is idle.
                     state     <= IDLE;
                     bus.grant <= 4'b0000;
                     bus.valid <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_arbitro_roteamento.sv
// Directed bench for arbitro_roteamento. One instance uses MAX_BURST=4 and a second uses MAX_BURST=1.
// Expected values are hand-computed from the arbitration rules.
module tb_arbitro_roteamento;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   arbitro_roteamento_if #(.MAX_BURST(4)) bus_a ();
   arbitro_roteamento_if #(.MAX_BURST(1)) bus_b ();

   arbitro_roteamento #(.N_BITS(4), .MAX_BURST(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   arbitro_roteamento #(.N_BITS(4), .MAX_BURST(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input int sel, input int gnt, input int vld, input int cnt);
      chk({tag, ".sel"},   int'(bus_a.SEL),       sel);
      chk({tag, ".grant"}, int'(bus_a.grant),     gnt);
      chk({tag, ".valid"}, int'(bus_a.valid),     vld);
      chk({tag, ".cnt"},   int'(bus_a.burst_cnt), cnt);
   endtask

   initial begin
      reset = 1'b1;
      bus_a.req = 4'b1111; bus_a.ready = 1'b0;
      bus_b.req = 4'b0000; bus_b.ready = 1'b0;
      tick();
      chk_a("reset", 0, 0, 0, 0);
      chk("reset_b.valid", int'(bus_b.valid), 0);

      // Leave reset with every source requesting. A wins because ptr is 0.
      reset = 1'b0;
      tick();
      chk_a("first_grant", 0, 1, 1, 0);
      tick();
      chk_a("hold_noready", 0, 1, 1, 0);

      // Four beats per source, then rotation, with no bubbles.
      bus_a.ready = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk($sformatf("rr%0d.sel", k), int'(bus_a.SEL), (k / 4) % 4);
         chk($sformatf("rr%0d.cnt", k), int'(bus_a.burst_cnt), k % 4);
         chk($sformatf("rr%0d.valid", k), int'(bus_a.valid), 1);
      end

      // Only C requests. A withdraws and C takes the grant.
      bus_a.req = 4'b0100; bus_a.ready = 1'b0;
      tick();
      chk_a("c_grant", 2, 4, 1, 0);
      bus_a.ready = 1'b1; tick(); chk_a("c_r1", 2, 4, 1, 1);
      bus_a.ready = 1'b0; tick(); chk_a("c_r0", 2, 4, 1, 1);
      bus_a.ready = 1'b1; tick(); chk_a("c_r1b", 2, 4, 1, 2);
      bus_a.ready = 1'b0; tick(); chk_a("c_r0b", 2, 4, 1, 2);
      bus_a.ready = 1'b1; tick(); chk_a("c_r1c", 2, 4, 1, 3);
      tick(); chk_a("c_regrant", 2, 4, 1, 0);

      // Steer the grant to B, then B withdraws and D takes over.
      bus_a.req = 4'b1010; bus_a.ready = 1'b0;
      tick(); chk_a("to_d", 3, 8, 1, 0);
      bus_a.req = 4'b0010;
      tick(); chk_a("to_b", 1, 2, 1, 0);
      bus_a.req = 4'b1010;
      tick(); chk_a("b_hold", 1, 2, 1, 0);
      bus_a.req = 4'b1000;
      tick(); chk_a("b_drop", 3, 8, 1, 0);

      // Reset mid-burst while a transfer is pending.
      bus_a.ready = 1'b1;
      tick(); chk("mid_cnt1", int'(bus_a.burst_cnt), 1);
      tick(); chk("mid_cnt2", int'(bus_a.burst_cnt), 2);
      reset = 1'b1;
      tick(); chk_a("mid_reset", 0, 0, 0, 0);
      reset = 1'b0; bus_a.req = 4'b1111; bus_a.ready = 1'b0;
      tick(); chk_a("restart", 0, 1, 1, 0);

      // All requests drop, so the arbiter goes idle and SEL is kept. ptr is now 1.
      bus_a.req = 4'b0000;
      tick(); chk_a("to_idle", 0, 0, 0, 0);
      bus_a.req = 4'b0100;
      tick(); chk_a("idle_latency", 2, 4, 1, 0);

      // With MAX_BURST=1, A and D alternate on every beat.
      bus_b.req = 4'b1001; bus_b.ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("mb1_%0d.sel", k), int'(bus_b.SEL), (k % 2 == 0) ? 0 : 3);
         chk($sformatf("mb1_%0d.cnt", k), int'(bus_b.burst_cnt), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
